cpu_fetch_q: RTL
================

Name: cpu_fetch_q

Overview:
Parametrised prefetching instruction-fetch unit for the next-generation cpu core. It replaces the single-register pc/ir fetch stage, which had no backpressure.
- Issues in-order reads to instruction memory and buffers returned words with their PCs in a DEPTH-entry queue.
- Presents words to decode through a valid/ready handshake.
- Squashes stale in-flight and queued words when execute redirects the PC.

Parameters:
AWIDTH, 16, instruction address / PC width
DWIDTH, 16, instruction word width
DEPTH, 4, queue entries and maximum in-flight reads; power of 2, >= 2
RESET_PC, 0, first fetch address after reset
INS_NOP, 16'h0001, value driven on ir when queue empty

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
ins_rd_addr  out  AWIDTH  fetch address, valid when ins_rd_req=1
ins_rd_req  out  1  read request; memory accepts every asserted cycle
ins_rd_data  in  DWIDTH  returned word, valid when ins_rd_rdy=1
ins_rd_rdy  in  1  response strobe; responses in request order, latency >= 1
redirect  in  1  execute requests branch to redirect_pc
redirect_pc  in  AWIDTH  branch target
ir  out  DWIDTH  queue-head instruction (INS_NOP when empty)
ir_pc  out  AWIDTH  PC of ir (0 when empty)
ir_valid  out  1  queue non-empty
ir_ready  in  1  decode accepts head; pop when ir_valid & ir_ready & !redirect

Behaviour:
- Reset (async, reset_n=0), effective immediately without a clock edge:
  - queue empty, live=0, drop=0, fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - ins_rd_req=0, ir_valid=0, ir=INS_NOP, ir_pc=0.
  - Memory is reset alongside this block; no responses may arrive for pre-reset requests.
- State:
  - fetch_pc: next address to request.
  - live: count of issued, non-squashed reads.
  - drop: count of squashed reads still in flight.
  - resp_pc: PC of the next live response.
  - Queue holds {word, pc}.
  - All counters are clog2(DEPTH+1) bits.
- Credit rule (registered values only, no same-cycle pop bypass): issue_ok = reset_n & (count + live + drop < DEPTH).
- Request outputs (combinational):
  - ins_rd_req = issue_ok.
  - ins_rd_addr = redirect ? redirect_pc : fetch_pc.
  - On issue: fetch_pc <= ins_rd_addr + 1, modulo 2^AWIDTH (wraps FFFF->0000 at AWIDTH=16).
- Responses (ins_rd_rdy=1):
  - If drop>0: decrement drop, discard word.
  - Else if redirect this cycle: discard word; it counts as one of the squashed live reads.
  - Else: push {ins_rd_data, resp_pc}, resp_pc <= resp_pc+1, live decrements.
  - A response with live=drop=0 is a protocol error; the bench asserts it never occurs.
- Redirect (single cycle):
  - Flush queue (count <= 0); any pop that cycle is ignored.
  - drop <= drop + live - (live response this cycle ? 1 : 0).
  - resp_pc <= redirect_pc.
  - If issue_ok: request redirect_pc this cycle; live <= 1, else live <= 0.
  - Back-to-back redirects: each later one squashes everything from the earlier.
- Simultaneous push and pop in the same cycle: both occur and count is unchanged.
- Output timing: a word returned in cycle N is visible on ir/ir_valid in cycle N+1 (registered queue, no bypass).
- ir, ir_pc and ir_valid depend only on registered state, with no combinational path from ir_ready or redirect.
- Invariant: count + live + drop <= DEPTH at all times, so the queue never overflows.
- Throughput: with 1-cycle memory latency and ir_ready held 1, one instruction per cycle is sustained.

Test Plan:
1. Release reset, 1-cycle memory returning data=addr^16'hA5A5, ir_ready=1.
   - ins_rd_addr 0000,0001,0002... on consecutive cycles.
   - First ir_valid 2 cycles after release with ir_pc=0000, ir=A5A5, then one word per cycle.
2. ir_ready=0 after reset.
   - Exactly 4 requests issued (0..3), then ins_rd_req=0.
   - Queue holds pcs 0..3.
   - Raising ir_ready pops in order, and each pop re-enables one request.
3. 3-cycle memory latency; redirect to 0x0100 with 2 reads live and 1 queued.
   - Queue flushes and both late responses are discarded.
   - Next ir_valid word has ir_pc=0x0100; no pc 0x0001-0x0003 appears.
4. Redirect 0x0100 then redirect 0x0200 next cycle, 2-cycle latency.
   - Only pcs 0x0200, 0x0201... ever reach ir_valid.
   - drop returns to 0.
5. RESET_PC=16'hFFFE.
   - Requests FFFE, FFFF, 0000, 0001.
   - ir_pc sequence matches, with no stall at the wrap.
6. Drop reset_n asynchronously mid-stream with the queue full.
   - ir_valid=0, ins_rd_req=0, ir=INS_NOP before the next clk edge.
   - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_fetch_q.sv
// cpu_fetch_q - prefetching instruction-fetch unit.
//
// Issues in-order reads to instruction memory. Returned words are buffered
// with their PCs in a DEPTH-entry queue and presented to decode through a
// valid/ready handshake. A redirect from execute flushes the queue and marks
// every read still in flight as stale, so stale words are discarded when
// they come back.
//
// Ports:
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   ins_rd_addr  fetch address, valid while ins_rd_req=1
//   ins_rd_req   read request; memory accepts every asserted cycle
//   ins_rd_data  returned instruction word, valid while ins_rd_rdy=1
//   ins_rd_rdy   response strobe; responses in request order, latency >= 1
//   redirect     execute requests a branch to redirect_pc (single cycle)
//   redirect_pc  branch target
//   ir           queue-head instruction (INS_NOP when empty)
//   ir_pc        PC of ir (0 when empty)
//   ir_valid     queue non-empty
//   ir_ready     decode accepts the head word
module cpu_fetch_q #(
  parameter int                 AWIDTH   = 16,
  parameter int                 DWIDTH   = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0,
  parameter logic [DWIDTH-1:0]  INS_NOP  = {{(DWIDTH-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [AWIDTH-1:0] ins_rd_addr,
  output logic              ins_rd_req,
  input  logic [DWIDTH-1:0] ins_rd_data,
  input  logic              ins_rd_rdy,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic [DWIDTH-1:0] ir,
  output logic [AWIDTH-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 2;

  // Queue pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  // Control state
  logic [CW-1:0]     count, count_nxt;
  logic [CW-1:0]     live, live_nxt;
  logic [CW-1:0]     drop, drop_nxt;
  logic [PW-1:0]     rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]     wr_ptr, wr_ptr_nxt;
  logic [AWIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [AWIDTH-1:0] resp_pc, resp_pc_nxt;

  // Queue storage (data only, never reset)
  logic [DWIDTH-1:0] word_mem [DEPTH];
  logic [AWIDTH-1:0] pc_mem   [DEPTH];

  logic [SW-1:0] occupancy;
  logic          issue_ok;
  logic          rsp_drop;
  logic          rsp_squash;
  logic          rsp_taken;
  logic          push;
  logic          pop;

  // Credit check uses registered counts only: a slot freed by a pop this
  // cycle is not reusable until the next cycle, which keeps ins_rd_req free
  // of any path from ir_ready.
  assign occupancy = SW'(count) + SW'(live) + SW'(drop);
  assign issue_ok  = reset_n && (occupancy < SW'(DEPTH));

  assign ins_rd_req  = issue_ok;
  assign ins_rd_addr = redirect ? redirect_pc : fetch_pc;

  // Response classification. Stale reads from an earlier redirect are
  // consumed first; a live response arriving on a redirect cycle is stale
  // too. A push requires an outstanding live read so that a stray strobe
  // cannot corrupt the counters.
  assign rsp_drop   = ins_rd_rdy && (drop != '0);
  assign rsp_squash = ins_rd_rdy && (drop == '0) && redirect && (live != '0);
  assign rsp_taken  = rsp_drop || rsp_squash;
  assign push       = ins_rd_rdy && (drop == '0) && !redirect && (live != '0);
  assign pop        = ir_valid && ir_ready && !redirect;

  // Outputs come from registered state only.
  assign ir_valid = (count != '0);
  assign ir       = ir_valid ? word_mem[rd_ptr] : INS_NOP;
  assign ir_pc    = ir_valid ? pc_mem[rd_ptr]   : '0;

  always_comb begin
    count_nxt    = count;
    live_nxt     = live;
    drop_nxt     = drop;
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    resp_pc_nxt  = resp_pc;
    fetch_pc_nxt = fetch_pc;

    if (redirect) begin
      // Everything queued is discarded and every live read becomes stale,
      // except one consumed by a response in this same cycle.
      count_nxt   = '0;
      rd_ptr_nxt  = '0;
      wr_ptr_nxt  = '0;
      drop_nxt    = drop + live - CW'(rsp_taken);
      live_nxt    = issue_ok ? CW'(1) : '0;
      resp_pc_nxt = redirect_pc;
    end else begin
      if (push) begin
        wr_ptr_nxt  = ptr_inc(wr_ptr);
        resp_pc_nxt = resp_pc + AWIDTH'(1);
      end
      if (pop) begin
        rd_ptr_nxt = ptr_inc(rd_ptr);
      end
      count_nxt = count + CW'(push) - CW'(pop);
      live_nxt  = live + CW'(issue_ok) - CW'(push);
      drop_nxt  = drop - CW'(rsp_drop);
    end

    // Without a credit on a redirect cycle the target is still remembered
    // so fetch resumes there once room frees up.
    if (issue_ok) begin
      fetch_pc_nxt = ins_rd_addr + AWIDTH'(1);
    end else if (redirect) begin
      fetch_pc_nxt = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      live     <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else begin
      count    <= count_nxt;
      live     <= live_nxt;
      drop     <= drop_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      fetch_pc <= fetch_pc_nxt;
      resp_pc  <= resp_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= ins_rd_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  // The credit rule guarantees the queue can never overflow.
  a_occupancy: assert property (@(posedge clk) disable iff (!reset_n)
    occupancy <= SW'(DEPTH));

endmodule
